// File: rtl/fetch_32.sv
// MIPS-32 instruction fetch stage with IF/ID register.
// Owns the PC, drives a req/ack instruction memory port and squashes the wrong-path fetch on redirect.
module fetch_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  branch,
  input  logic [1:0]  jump,
  input  logic        zero,
  input  logic [31:0] jr_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        err_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_buf, r_id_instr, r_id_pc4;
  logic        r_id_valid;

  logic        w_taken, w_redir;
  logic [31:0] w_pc4, w_br_off, w_target;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_id_instr[15]}}, r_id_instr[15:0], 2'b00};
  assign w_taken  = ((branch == 2'b01) && zero) || ((branch == 2'b10) && !zero);
  assign w_redir  = r_id_valid && !stall && ((jump != 2'b00) || w_taken);

  // Jumps take precedence over branches when both are flagged.
  always_comb begin
    w_target = r_id_pc4 + w_br_off;
    case (jump)
      2'b01, 2'b10: w_target = {r_id_pc4[31:28], r_id_instr[25:0], 2'b00};
      2'b11:        w_target = {jr_addr[31:2], 2'b00};
      default:      ;
    endcase
  end

  assign err_misaligned = w_redir && (jump == 2'b11) && (jr_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (!w_redir && stall && imem_ack) w_state_nxt = S_HOLD;
      end
      S_HOLD: if (w_redir || !stall) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A word that lands while stalled is parked in r_buf so it is neither lost nor refetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_buf      <= 32'd0;
      r_id_instr <= 32'd0;
      r_id_pc4   <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (w_redir) begin
      r_pc       <= w_target;
      r_id_instr <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (stall) begin
      if (r_state == S_REQ && imem_ack) r_buf <= imem_rdata;
    end else if (r_state == S_REQ && imem_ack) begin
      r_id_instr <= imem_rdata;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
      r_pc       <= w_pc4;
    end else if (r_state == S_HOLD) begin
      r_id_instr <= r_buf;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
      r_pc       <= w_pc4;
    end else if (r_state == S_REQ) begin
      r_id_instr <= 32'd0;
      r_id_valid <= 1'b0;
    end
  end

  assign imem_addr   = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc4;
  assign id_valid    = r_id_valid;
  assign opcode      = r_id_instr[31:26];
  assign funct       = r_id_instr[5:0];

endmodule

// File: tb/tb_fetch_32.sv
// Directed bench for fetch_32: imem model, small control_32 decode, per-scenario tasks.
module tb_fetch_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, stall, zero, id_valid, err_misaligned;
  logic [31:0] imem_addr, imem_rdata, jr_addr, id_instr, id_pc_plus4;
  logic [1:0]  branch, jump;
  logic [5:0]  opcode, funct;
  logic [31:0] mem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  fetch_32 #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
    .jump(jump), .zero(zero), .jr_addr(jr_addr), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  // Stand-in for control_32: beq=4, bne=5, j=2, jal=3, jr = R-type funct 8.
  always_comb begin
    branch = 2'b00;
    jump   = 2'b00;
    case (opcode)
      6'h04: branch = 2'b01;
      6'h05: branch = 2'b10;
      6'h02: jump   = 2'b01;
      6'h03: jump   = 2'b10;
      6'h00: if (funct == 6'h08) jump = 2'b11;
      default: ;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Default image: addi words tagged with their own address.
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b1; zero = 1'b0; jr_addr = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | (i << 2);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc4(input logic [31:0] p4);
    for (int i = 0; i < 60; i++) begin
      if (id_valid === 1'b1 && id_pc_plus4 === p4) return;
      tick();
    end
    n_tests++; n_fail++;
    $display("FAIL wait_pc4: timeout waiting for id_pc_plus4 %h, got %h", p4, id_pc_plus4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b1; zero = 1'b0; jr_addr = 32'h0;
    tick(); tick();
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h0); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    n_tests++; if (id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_id: got %h/%h want 0/0", id_instr, id_pc_plus4); end
    n_tests++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_misaligned); end
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    do_reset();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_idle_req: got %b want 0", imem_req); end
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_c1: got req %b addr %h vld %b want 1 0 0", imem_req, imem_addr, id_valid); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h4 || id_instr !== 32'h2000_0000) begin n_fail++; $display("FAIL seq_first: got vld %b pc4 %h ins %h want 1 4 20000000", id_valid, id_pc_plus4, id_instr); end
    for (int i = 2; i < 6; i++) begin
      tick();
      n_tests++; if (imem_addr !== 32'(i * 4) || id_pc_plus4 !== 32'(i * 4) || id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_%0d: got addr %h pc4 %h want %h", i, imem_addr, id_pc_plus4, i * 4); end
    end
  endtask

  task automatic test_branch();
    do_reset(); mem[4] = 32'h1000_0003; zero = 1'b1;
    wait_pc4(32'h14);
    n_tests++; if (opcode !== 6'h04) begin n_fail++; $display("FAIL beq_op: got %h want 04", opcode); end
    tick();
    n_tests++; if (imem_addr !== 32'h20 || id_valid !== 1'b0 || opcode !== 6'h0) begin n_fail++; $display("FAIL beq_taken: got addr %h vld %b op %h want 20 0 0", imem_addr, id_valid, opcode); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h24 || id_instr !== 32'h2000_0020) begin n_fail++; $display("FAIL beq_target: got vld %b pc4 %h ins %h want 1 24 20000020", id_valid, id_pc_plus4, id_instr); end

    do_reset(); mem[4] = 32'h1000_0003; zero = 1'b0;
    wait_pc4(32'h14);
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h18 || imem_addr !== 32'h18) begin n_fail++; $display("FAIL beq_nt: got vld %b pc4 %h addr %h want 1 18 18", id_valid, id_pc_plus4, imem_addr); end

    do_reset(); mem[4] = 32'h1400_FFFC; zero = 1'b0;
    wait_pc4(32'h14);
    tick();
    n_tests++; if (imem_addr !== 32'h4 || id_valid !== 1'b0) begin n_fail++; $display("FAIL bne_back: got addr %h vld %b want 4 0", imem_addr, id_valid); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL bne_target: got vld %b pc4 %h want 1 8", id_valid, id_pc_plus4); end
  endtask

  task automatic test_jump();
    do_reset(); mem[2] = 32'h0800_0040; mem[64] = 32'h0000_0008; jr_addr = 32'h203;
    wait_pc4(32'hC);
    n_tests++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL j_err: got %b want 0", err_misaligned); end
    tick();
    n_tests++; if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin n_fail++; $display("FAIL j_target: got addr %h vld %b want 100 0", imem_addr, id_valid); end
    wait_pc4(32'h104);
    n_tests++; if (err_misaligned !== 1'b1) begin n_fail++; $display("FAIL jr_err: got %b want 1", err_misaligned); end
    tick();
    n_tests++; if (imem_addr !== 32'h200 || err_misaligned !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL jr_target: got addr %h err %b vld %b want 200 0 0", imem_addr, err_misaligned, id_valid); end
  endtask

  task automatic test_wrap();
    do_reset(); mem[1] = 32'h0000_0008; jr_addr = 32'hFFFF_FFFC;
    wait_pc4(32'h8);
    n_tests++; if (err_misaligned !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", err_misaligned); end
    tick();
    n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jr: got %h want fffffffc", imem_addr); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || id_instr !== mem[255]) begin n_fail++; $display("FAIL wrap_pc4: got vld %b pc4 %h addr %h ins %h", id_valid, id_pc_plus4, imem_addr, id_instr); end
  endtask

  task automatic test_stall();
    do_reset();
    wait_pc4(32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (imem_req !== 1'b0 || id_pc_plus4 !== 32'h8 || id_instr !== 32'h2000_0004 || id_valid !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_%0d: got req %b pc4 %h ins %h vld %b addr %h", i, imem_req, id_pc_plus4, id_instr, id_valid, imem_addr); end
    end
    stall = 1'b0;
    tick();
    n_tests++; if (id_instr !== 32'h2000_0008 || id_pc_plus4 !== 32'hC || id_valid !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_drain: got ins %h pc4 %h vld %b addr %h want 20000008 c 1 c", id_instr, id_pc_plus4, id_valid, imem_addr); end
    tick();
    n_tests++; if (id_instr !== 32'h2000_000C || id_pc_plus4 !== 32'h10) begin n_fail++; $display("FAIL stall_resume: got ins %h pc4 %h want 2000000c 10", id_instr, id_pc_plus4); end
  endtask

  task automatic test_ack_low();
    do_reset();
    wait_pc4(32'h8);
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_valid !== 1'b0 || opcode !== 6'h0) begin n_fail++; $display("FAIL ackl_%0d: got req %b addr %h vld %b op %h", i, imem_req, imem_addr, id_valid, opcode); end
    end
    imem_ack = 1'b1;
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_instr !== 32'h2000_0008 || id_pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL ackl_deliver: got vld %b ins %h pc4 %h want 1 20000008 c", id_valid, id_instr, id_pc_plus4); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_pc4(32'h8);
    stall = 1'b1;
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got req %b want 0", imem_req); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || imem_req !== 1'b0 || id_instr !== 32'h0) begin n_fail++; $display("FAIL rmid_async: got addr %h vld %b req %b ins %h", imem_addr, id_valid, imem_req, id_instr); end
    tick();
    stall = 1'b0; imem_ack = 1'b1; rst_n = 1'b1;
    tick();
    n_tests++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_late_ack: got vld %b req %b addr %h want 0 1 0", id_valid, imem_req, imem_addr); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h4 || id_instr !== 32'h2000_0000) begin n_fail++; $display("FAIL rmid_restart: got vld %b pc4 %h ins %h want 1 4 20000000", id_valid, id_pc_plus4, id_instr); end
  endtask

  initial begin
    imem_ack = 1'b1; stall = 1'b0; zero = 1'b0; jr_addr = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | (i << 2);
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_wrap();
    test_stall();
    test_ack_low();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fetch_32.md
Name: fetch_32

Overview:
- Instruction fetch stage plus IF/ID register for the 32-bit MIPS core; sits directly upstream of control_32.
- Owns the PC and drives a req/ack instruction-memory port.
- Presents the decoded-stage instruction, whose opcode and funct slices feed control_32.
- Consumes control_32's branch/jump outputs and the ID-stage compare result to redirect the PC; no delay slot, so the wrong-path fetch is squashed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; high in S_REQ only
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  imem_rdata valid this cycle; ignored when imem_req=0
imem_rdata  in  32  fetched instruction word
stall  in  1  hazard stall from ID/EX; freezes pc and IF/ID
branch  in  2  from control_32: 00 none, 01 beq, 10 bne, 11 reserved (no redirect)
jump  in  2  from control_32: 00 none, 01 j, 10 jal, 11 jr
zero  in  1  ID-stage rs==rt compare result
jr_addr  in  32  rs register value for jr
id_instr  out  32  IF/ID instruction; 0 (nop) when id_valid=0
id_pc_plus4  out  32  PC+4 of id_instr
id_valid  out  1  id_instr is a real instruction
opcode  out  6  id_instr[31:26], to control_32
funct  out  6  id_instr[5:0], to control_32
err_misaligned  out  1  one-cycle pulse when a jr target has bits [1:0] != 00

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_IDLE.
  - id_instr=0, id_pc_plus4=0, id_valid=0, err_misaligned=0.
  - buf (32-bit skid register) = 0.
  - imem_req=0.
- Reset asserted mid-fetch:
  - Outstanding ack is abandoned.
  - An imem_ack arriving after release is ignored unless imem_req=1.
- States:
  - S_IDLE: one cycle after reset release, then -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_HOLD: imem_req=0; buf holds a fetched word blocked by stall.
- Redirect, evaluated combinationally each cycle, with redir = id_valid & !stall & (jump!=00 | taken):
  - taken = (branch==01 & zero) | (branch==10 & !zero).
  - Target precedence: jump over branch.
  - jump 01/10 -> {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - jump 11 -> {jr_addr[31:2], 2'b00}; err_misaligned=1 for that cycle if jr_addr[1:0]!=0.
  - Taken branch -> id_pc_plus4 + (sign_extend(id_instr[15:0]) << 2), mod 2^32.
- Per-cycle priority, highest first:
  1. redir: pc<=target; id_valid<=0; id_instr<=0; any ack this cycle and any buf content are discarded; state<=S_REQ.
  2. stall: pc, id_* frozen.
     - S_REQ with imem_ack: buf<=imem_rdata, state<=S_HOLD.
     - S_HOLD: remain.
  3. S_REQ & imem_ack: id_instr<=imem_rdata, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  4. S_HOLD (stall low): id_instr<=buf, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4, state<=S_REQ.
  5. S_REQ, no ack, no stall: id_valid<=0, id_instr<=0 (bubble); pc held; imem_req stays high.
- Latency and throughput:
  - With imem_ack tied high, one instruction per cycle.
  - First valid id_instr appears 2 cycles after reset release.
- Redirect penalty: exactly one bubble (the squashed sequential fetch).
- pc+4 wraps mod 2^32 at 32'hFFFF_FFFC -> 0.
- opcode and funct are pure slices of id_instr, so a bubble presents r_type/funct 0 (nop) to control_32.

Test Plan:
- Reset release, RESET_PC=0, ack always 1, sequential words -> imem_addr 0,4,8...; id_valid first high 2 cycles after release with id_pc_plus4=4.
- beq at PC 0x10, imm=0x0003, zero=1 -> next imem_addr 0x20; one bubble (id_valid=0, opcode=0); same instruction with zero=0 -> no redirect, 0x18 proceeds.
- Instruction j 0x0000040 at PC 0x8 -> next imem_addr 0x100; jr with jr_addr=0x203 -> imem_addr 0x200 and err_misaligned high one cycle.
- stall high for 3 cycles while ack arrives in first -> state S_HOLD, imem_req=0, id_* unchanged; stall low -> buffered word enters id_instr, fetch resumes at pc+4, no word lost or duplicated.
- ack held low 4 cycles -> imem_req stays 1, imem_addr constant, id_valid=0 bubbles; ack then delivers correct word.
- rst_n pulsed low mid-stream while in S_HOLD -> immediate pc=RESET_PC, id_valid=0, imem_req=0; late ack ignored.
